// File: rtl/sync_cs_dev_param.sv
// sync_cs_dev_param: parametrised synchronous chip-select slave memory.
// Strobes are decoded live. Latency counts run off registered counters.
// Adds byte enables, an incrementing burst mode, and synchronous reset
// of the access logic. Memory contents survive reset.
module sync_cs_dev_param #(
    parameter int DW         = 32,
    parameter int AW         = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 4,
    parameter int WR_LAT     = 3,
    parameter int ACK_LAT    = 2,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     addr,
    inout  wire  [DW-1:0]     dq,
    input  logic              cs_,
    input  logic              we_,
    input  logic              oe_,
    input  logic [DW/8-1:0]   be_,
    input  logic              burst_,
    output logic              ack_
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Latencies widened by one bit so that "cnt >= LAT" can be written as
    // "cnt + 1 > LAT"; this stays well-formed when a latency is 0.
    localparam logic [CNT_W:0]        RD_LAT_W  = (CNT_W+1)'(RD_LAT);
    localparam logic [CNT_W:0]        WR_LAT_W  = (CNT_W+1)'(WR_LAT);
    localparam logic [CNT_W:0]        ACK_LAT_W = (CNT_W+1)'(ACK_LAT);
    localparam logic [CNT_W:0]        ONE_W     = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;
    localparam logic [DEPTH_LOG2-1:0] BEAT_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_XFER, WR_WAIT, WR_XFER} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]  beat_q, beat_d;
    logic [DW-1:0]          data_o_q, data_o_d;
    logic [DW-1:0]          mem [DEPTH];

    logic                   rd, wr, act;
    logic                   rd_ph, wr_ph, type_chg, clr;
    logic [CNT_W:0]         cnt_p1, cnt_p2;
    logic                   rd_ok, wr_ok, ack_ok, rd_hit, wr_hit;
    logic                   rd_xfer, wr_xfer;
    logic [DEPTH_LOG2-1:0]  ea, ea_next;

    assign rd  = ~cs_ & we_ & ~oe_;
    assign wr  = ~cs_ & ~we_;
    assign act = rd | wr;

    // A type change is detected against the phase held in the state register.
    assign rd_ph    = (state_q == RD_WAIT) || (state_q == RD_XFER);
    assign wr_ph    = (state_q == WR_WAIT) || (state_q == WR_XFER);
    assign type_chg = (rd & wr_ph) | (wr & rd_ph);
    assign clr      = rst | ~act | type_chg;

    assign cnt_p1 = {1'b0, cnt_q} + ONE_W;
    assign cnt_p2 = cnt_p1 + ONE_W;
    assign rd_ok  = cnt_p1 > RD_LAT_W;
    assign wr_ok  = cnt_p1 > WR_LAT_W;
    assign ack_ok = cnt_p1 > ACK_LAT_W;
    assign rd_hit = cnt_p2 > RD_LAT_W;
    assign wr_hit = cnt_p2 > WR_LAT_W;

    // In the cycle where the strobe type flips, the counter still holds the
    // old access's count. That cycle is masked, so the new access must
    // wait out its own latency.
    assign rd_xfer = rd & rd_ok & ~type_chg;
    assign wr_xfer = wr & wr_ok & ~type_chg;

    assign ea      = addr[DEPTH_LOG2-1:0] + (burst_ ? '0 : beat_q);
    assign ea_next = addr[DEPTH_LOG2-1:0] + (burst_ ? '0 : beat_d);

    assign dq   = rd_xfer ? data_o_q : {DW{1'bz}};
    assign ack_ = ~(act & ack_ok);

    generate
        if (AW > DEPTH_LOG2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[AW-1:DEPTH_LOG2];
        end
    endgenerate

    // Access phase tracking: wait/transfer per direction, idle when no strobe.
    always_comb begin
        state_d = state_q;
        if (!act) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = rd ? RD_WAIT : WR_WAIT;
                RD_WAIT: if (wr) state_d = WR_WAIT; else if (rd_hit) state_d = RD_XFER;
                RD_XFER: if (wr) state_d = WR_WAIT;
                WR_WAIT: if (rd) state_d = RD_WAIT; else if (wr_hit) state_d = WR_XFER;
                WR_XFER: if (rd) state_d = RD_WAIT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Counter, burst beat and read-data prefetch for the next cycle.
    always_comb begin
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        data_o_d = data_o_q;
        if (clr) begin
            cnt_d  = '0;
            beat_d = '0;
        end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            if (!burst_ && (rd_xfer || wr_xfer))
                beat_d = beat_q + BEAT_ONE;
        end
        data_o_d = rst ? '0 : mem[ea_next];
    end

    // Access-control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            beat_q   <= '0;
            data_o_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            data_o_q <= data_o_d;
        end
    end

    // Byte-masked write into the array; reset only suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && wr_xfer) begin
            for (int i = 0; i < NB; i++) begin
                if (!be_[i])
                    mem[ea][8*i +: 8] <= dq[8*i +: 8];
            end
        end
    end

    // Load every word with pseudo-random data.
    task automatic mem_fill();
        logic [DW-1:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            for (int b = 0; b < NB; b++)
                w[8*b +: 8] = 8'($random);
            mem[i] <= w;
        end
    endtask

    // Zero every word.
    task automatic mem_clear();
        for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
    endtask

endmodule
